// File: rtl/mul_div_iter.sv
// mul_div_iter: iterative multiply/divide unit for the execute stage.
// MUL/MULU use shift-add and DIV/DIVU use restoring division. Each takes one
// step per cycle for WIDTH cycles, followed by a single sign-fix cycle.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start, op      request (sampled in IDLE); 0 MUL, 1 MULU, 2 DIV, 3 DIVU
//   src1, src2     multiplicand/dividend, multiplier/divisor
//   cancel         pipeline flush; aborts any in-flight operation
//   busy           operation in flight (CALC or FIX)
//   result_valid   one-cycle pulse when result_lo/result_high update
//   result_lo      product low half / quotient
//   result_high    product high half / remainder
module mul_div_iter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             cancel,
   output logic             busy,
   output logic             result_valid,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_high
);

   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [W2-1:0]    acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic [WIDTH-1:0] opb;       // multiplicand or divisor magnitude
   logic             is_div;
   logic             neg_lo;    // negate product, or negate quotient
   logic             neg_hi;    // negate remainder (sign of dividend)
   logic             div_zero;

   // Operand signs and magnitudes (op[0] set means unsigned)
   logic             sign1_c, sign2_c;
   logic [WIDTH-1:0] mag1_c, mag2_c;

   assign sign1_c = src1[WIDTH-1] & ~op[0];
   assign sign2_c = src2[WIDTH-1] & ~op[0];
   assign mag1_c  = sign1_c ? (~src1 + WIDTH'(1)) : src1;
   assign mag2_c  = sign2_c ? (~src2 + WIDTH'(1)) : src2;

   // One iteration step for each algorithm
   logic [WIDTH-1:0] addend_c;
   logic [WIDTH:0]   mul_sum_c;
   logic [WIDTH:0]   rem_sh_c;
   logic [WIDTH:0]   trial_c;
   logic [W2-1:0]    mul_next_c;
   logic [W2-1:0]    div_next_c;

   always_comb begin
      addend_c   = acc[0] ? opb : '0;
      mul_sum_c  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, addend_c};
      mul_next_c = {mul_sum_c, acc[WIDTH-1:1]};
      // Shift the next dividend bit into the remainder and trial-subtract
      rem_sh_c   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
      trial_c    = rem_sh_c - {1'b0, opb};
      if (trial_c[WIDTH]) begin
         div_next_c = {rem_sh_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         div_next_c = {trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
   end

   // Sign correction applied in FIX
   logic [W2-1:0]    prod_fix_c;
   logic [WIDTH-1:0] quo_fix_c;
   logic [WIDTH-1:0] rem_fix_c;

   always_comb begin
      prod_fix_c = neg_lo ? (~acc + W2'(1)) : acc;
      quo_fix_c  = neg_lo ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
      rem_fix_c  = neg_hi ? (~acc[W2-1:WIDTH] + WIDTH'(1)) : acc[W2-1:WIDTH];
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         acc          <= '0;
         opb          <= '0;
         is_div       <= 1'b0;
         neg_lo       <= 1'b0;
         neg_hi       <= 1'b0;
         div_zero     <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result_lo    <= '0;
         result_high  <= '0;
      end else begin
         result_valid <= 1'b0;
         if (cancel) begin
            // Flush wins over start and leaves the result registers untouched
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     is_div   <= op[1];
                     neg_lo   <= sign1_c ^ sign2_c;
                     neg_hi   <= sign1_c;
                     opb      <= op[1] ? mag2_c : mag1_c;
                     acc      <= {{WIDTH{1'b0}}, (op[1] ? mag1_c : mag2_c)};
                     cnt      <= CNT_W'(WIDTH);
                     busy     <= 1'b1;
                     div_zero <= op[1] && (src2 == '0);
                     state    <= (op[1] && (src2 == '0)) ? S_FIX : S_CALC;
                  end
               end
               S_CALC: begin
                  acc <= is_div ? div_next_c : mul_next_c;
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state <= S_FIX;
                  end
               end
               S_FIX: begin
                  state        <= S_IDLE;
                  busy         <= 1'b0;
                  result_valid <= 1'b1;
                  if (div_zero) begin
                     result_lo   <= '0;
                     result_high <= '0;
                  end else if (is_div) begin
                     result_lo   <= quo_fix_c;
                     result_high <= rem_fix_c;
                  end else begin
                     result_lo   <= prod_fix_c[WIDTH-1:0];
                     result_high <= prod_fix_c[W2-1:WIDTH];
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_div_iter.sv
// Bench for mul_div_iter: drives a WIDTH=32 and a WIDTH=8 instance with shared
// stimulus. The 8-bit unit sees the low bytes of the operands. Outputs are
// compared every cycle against an arithmetic reference, and directed results
// are also checked against hand-computed constants.
module tb_mul_div_iter;

   logic        clk;
   logic        rst;
   logic        start;
   logic        cancel;
   logic [1:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;

   logic        busy32, valid32;
   logic [31:0] lo32, hi32;
   logic        busy8, valid8;
   logic [7:0]  lo8, hi8;

   int n_vec = 0;
   int n_err = 0;

   mul_div_iter #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
      .cancel(cancel), .busy(busy32), .result_valid(valid32),
      .result_lo(lo32), .result_high(hi32)
   );

   mul_div_iter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1[7:0]), .src2(src2[7:0]),
      .cancel(cancel), .busy(busy8), .result_valid(valid8),
      .result_lo(lo8), .result_high(hi8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic reference: returns {high, low} for a w-bit unit
   function automatic logic [63:0] ref_op(int unsigned w, logic [1:0] o, logic [31:0] a, logic [31:0] b);
      logic [63:0] mask, ua, ub, up, hi, lo;
      longint      sa, sb;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, a} & mask;
      ub   = {32'd0, b} & mask;
      sa   = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
      sb   = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
      hi   = 64'd0;
      lo   = 64'd0;
      case (o)
         2'd0: begin up = 64'(sa * sb); hi = (up >> w) & mask; lo = up & mask; end
         2'd1: begin up = ua * ub;      hi = (up >> w) & mask; lo = up & mask; end
         2'd2: if (ub != 64'd0) begin
                  lo = 64'(sa / sb) & mask;
                  hi = 64'(sa % sb) & mask;
               end
         default: if (ub != 64'd0) begin
                  lo = (ua / ub) & mask;
                  hi = (ua % ub) & mask;
               end
      endcase
      return {hi[31:0], lo[31:0]};
   endfunction

   // Handshake reference: cycles of busy left, pending and visible results
   int unsigned w_u [2] = '{32, 8};
   int          left [2];
   logic        m_valid [2];
   logic [31:0] m_lo [2], m_hi [2], p_lo [2], p_hi [2];

   always @(posedge clk or posedge rst) begin
      for (int u = 0; u < 2; u++) begin
         if (rst) begin
            left[u]    <= 0;
            m_valid[u] <= 1'b0;
            m_lo[u]    <= '0;
            m_hi[u]    <= '0;
            p_lo[u]    <= '0;
            p_hi[u]    <= '0;
         end else begin
            m_valid[u] <= 1'b0;
            if (left[u] != 0) begin
               if (cancel) begin
                  left[u] <= 0;
               end else begin
                  left[u] <= left[u] - 1;
                  if (left[u] == 1) begin
                     m_valid[u] <= 1'b1;
                     m_lo[u]    <= p_lo[u];
                     m_hi[u]    <= p_hi[u];
                  end
               end
            end else if (start && !cancel) begin
               {p_hi[u], p_lo[u]} <= ref_op(w_u[u], op, src1, src2);
               left[u] <= (op[1] && ((src2 & 32'((64'd1 << w_u[u]) - 64'd1)) == 32'd0))
                          ? 1 : int'(w_u[u]) + 1;
            end
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("u32 busy",  32'(busy32),  32'(left[0] != 0));
      chk("u32 valid", 32'(valid32), 32'(m_valid[0]));
      chk("u32 lo",    lo32,         m_lo[0]);
      chk("u32 hi",    hi32,         m_hi[0]);
      chk("u8 busy",   32'(busy8),   32'(left[1] != 0));
      chk("u8 valid",  32'(valid8),  32'(m_valid[1]));
      chk("u8 lo",     32'(lo8),     m_lo[1]);
      chk("u8 hi",     32'(hi8),     m_hi[1]);
   endtask

   // One clock: compare on the falling edge, return just after the rising edge
   task automatic step();
      @(negedge clk);
      compare();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and wait for the 32-bit result; latencies count from start
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat32, output int lat8);
      op = o; src1 = a; src2 = b; start = 1'b1;
      lat8 = 0;
      step();
      start = 1'b0;
      src1 = $urandom;
      src2 = $urandom;
      op = 2'($urandom_range(3, 0));
      for (lat32 = 1; lat32 < 200; lat32++) begin
         if (valid8 && lat8 == 0) lat8 = lat32;
         if (valid32) break;
         step();
      end
   endtask

   int l32, l8, nv;

   initial begin
      rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'd0; src1 = '0; src2 = '0;
      step();
      step();
      chk("reset lo32", lo32, 32'h0);
      chk("reset hi32", hi32, 32'h0);
      chk("reset busy32", 32'(busy32), 32'h0);
      rst = 1'b0;
      step();

      // Signed multiply with timing at both widths
      do_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, l32, l8);
      chk("mul lat32", 32'(l32), 32'd34);
      chk("mul lat8", 32'(l8), 32'd10);
      chk("mul hi32", hi32, 32'hFFFF_FFFF);
      chk("mul lo32", lo32, 32'hFFFF_FFEB);
      chk("mul hi8", 32'(hi8), 32'h0000_00FF);
      chk("mul lo8", 32'(lo8), 32'h0000_00EB);

      // Back-to-back starts from here on
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, l32, l8);
      chk("mulu lat32", 32'(l32), 32'd34);
      chk("mulu hi32", hi32, 32'hFFFF_FFFE);
      chk("mulu lo32", lo32, 32'h0000_0001);

      do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, l32, l8);
      chk("mul -1*-1 hi32", hi32, 32'h0000_0000);
      chk("mul -1*-1 lo32", lo32, 32'h0000_0001);

      do_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, l32, l8);
      chk("div lo32", lo32, 32'hFFFF_FFFD);
      chk("div hi32", hi32, 32'hFFFF_FFFF);

      do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, l32, l8);
      chk("div minneg lo32", lo32, 32'h8000_0000);
      chk("div minneg hi32", hi32, 32'h0000_0000);

      do_op(2'd3, 32'h0000_0064, 32'h0000_0007, l32, l8);
      chk("divu lo32", lo32, 32'h0000_000E);
      chk("divu hi32", hi32, 32'h0000_0002);

      // Cancel mid-CALC: no result, outputs keep the previous DIVU values
      op = 2'd0; src1 = 32'd5; src2 = 32'd6; start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk("cancel busy32", 32'(busy32), 32'h0);
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         if (valid32) nv++;
         step();
      end
      chk("cancel valids", 32'(nv), 32'd0);
      chk("cancel lo32", lo32, 32'h0000_000E);
      chk("cancel hi32", hi32, 32'h0000_0002);

      // Cancel during the FIX cycle
      op = 2'd1; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
      step();
      start = 1'b0;
      repeat (32) step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      nv = 0;
      for (int i = 0; i < 5; i++) begin
         if (valid32) nv++;
         step();
      end
      chk("cancel fix valids", 32'(nv), 32'd0);
      chk("cancel fix lo32", lo32, 32'h0000_000E);

      // Divide by zero
      do_op(2'd3, 32'h1234_5678, 32'h0000_0000, l32, l8);
      chk("dz lat32", 32'(l32), 32'd2);
      chk("dz lat8", 32'(l8), 32'd2);
      chk("dz lo32", lo32, 32'h0);
      chk("dz hi32", hi32, 32'h0);

      // Start pulses while busy are ignored
      op = 2'd0; src1 = 32'hFFFF_FFFD; src2 = 32'd7; start = 1'b1;
      step();
      start = 1'b0;
      nv = 0;
      for (int i = 1; i < 60; i++) begin
         if (valid32) nv++;
         start = (i == 5 || i == 20);
         op = 2'd3; src1 = 32'd100; src2 = 32'd3;
         step();
      end
      start = 1'b0;
      chk("ignore valids", 32'(nv), 32'd1);
      chk("ignore lo32", lo32, 32'hFFFF_FFEB);
      chk("ignore hi32", hi32, 32'hFFFF_FFFF);

      // Asynchronous reset mid-CALC
      op = 2'd0; src1 = 32'd123; src2 = 32'd45; start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      #2;
      rst = 1'b1;
      #1;
      chk("arst busy32", 32'(busy32), 32'h0);
      chk("arst valid32", 32'(valid32), 32'h0);
      chk("arst lo32", lo32, 32'h0);
      chk("arst hi32", hi32, 32'h0);
      chk("arst lo8", 32'(lo8), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
